// File: rtl/cache_req_queue.sv
// rtl/cache_req_queue.sv - Request FIFO for the cache lookup stage with tag/set/offset split and request statistics.
module cache_req_queue #(
    parameter int BLOCK_OFFSET_BITS = 3,
    parameter int SET_NO_BITS       = 3,
    parameter int DEPTH             = 8,
    localparam int TAG_W            = 24 - BLOCK_OFFSET_BITS - SET_NO_BITS,
    localparam int CNT_W            = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [24:0]                  in_query,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_write,
    output logic [23:0]                  out_addr,
    output logic [TAG_W-1:0]             out_tag,
    output logic [SET_NO_BITS-1:0]       out_set,
    output logic [BLOCK_OFFSET_BITS-1:0] out_offset,
    output logic [CNT_W-1:0]             count,
    output logic [31:0]                  req_total,
    output logic [31:0]                  write_total
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [24:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      req_total_q;
    logic [31:0]      write_total_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [24:0]      head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Flush wins over both sides; neither handshake takes effect in that cycle.
    assign push = in_valid && !full && !flush;
    assign pop  = !empty && out_ready && !flush;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;
    assign req_total   = req_total_q;
    assign write_total = write_total_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_query;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Statistics saturate rather than wrap so long traces never report a small total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_total_q   <= '0;
            write_total_q <= '0;
        end else if (push) begin
            if (req_total_q != 32'hFFFF_FFFF) begin
                req_total_q <= req_total_q + 32'd1;
            end
            if (in_query[24] && (write_total_q != 32'hFFFF_FFFF)) begin
                write_total_q <= write_total_q + 32'd1;
            end
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        out_write  = 1'b0;
        out_addr   = '0;
        out_tag    = '0;
        out_set    = '0;
        out_offset = '0;
        if (!empty) begin
            out_write  = head[24];
            out_addr   = head[23:0];
            out_tag    = head[23:24-TAG_W];
            out_set    = head[BLOCK_OFFSET_BITS+SET_NO_BITS-1:BLOCK_OFFSET_BITS];
            out_offset = head[BLOCK_OFFSET_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_cache_req_queue.sv
// tb/tb_cache_req_queue.sv - Randomized self-checking bench for cache_req_queue against a queue-based model.
module tb_cache_req_queue;

    localparam int OB    = 3;
    localparam int SB    = 3;
    localparam int DEPTH = 8;
    localparam int TAG_W = 24 - OB - SB;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [24:0]         in_query;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic                out_write;
    logic [23:0]         out_addr;
    logic [TAG_W-1:0]    out_tag;
    logic [SB-1:0]       out_set;
    logic [OB-1:0]       out_offset;
    logic [CNT_W-1:0]    count;
    logic [31:0]         req_total;
    logic [31:0]         write_total;

    int checks = 0;
    int errors = 0;

    logic [24:0] mq[$];
    logic [31:0] m_req;
    logic [31:0] m_wr;

    always #5 clk = ~clk;

    cache_req_queue #(
        .BLOCK_OFFSET_BITS(OB),
        .SET_NO_BITS(SB),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_query(in_query),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_write(out_write),
        .out_addr(out_addr),
        .out_tag(out_tag),
        .out_set(out_set),
        .out_offset(out_offset),
        .count(count),
        .req_total(req_total),
        .write_total(write_total)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned a;
        check({tag, ".count"}, 64'(count), 64'(mq.size()));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
        check({tag, ".req_total"}, 64'(req_total), 64'(m_req));
        check({tag, ".write_total"}, 64'(write_total), 64'(m_wr));
        if (mq.size() != 0) begin
            a = 32'(mq[0][23:0]);
            check({tag, ".out_write"}, 64'(out_write), 64'(mq[0][24]));
            check({tag, ".out_addr"}, 64'(out_addr), 64'(a));
            check({tag, ".out_tag"}, 64'(out_tag), 64'(a / (1 << (OB + SB))));
            check({tag, ".out_set"}, 64'(out_set), 64'((a / (1 << OB)) % (1 << SB)));
            check({tag, ".out_offset"}, 64'(out_offset), 64'(a % (1 << OB)));
        end else begin
            check({tag, ".idle_fields"},
                  64'({out_write, out_addr, out_tag, out_set, out_offset}), 64'd0);
        end
    endtask

    task automatic cycle(input string tag, input logic v, input logic [24:0] q,
                         input logic r, input logic f);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_query  = q;
        out_ready = r;
        flush     = f;
        do_push = v && (mq.size() < DEPTH) && !f;
        do_pop  = r && (mq.size() > 0) && !f;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(q);
                if (m_req != 32'hFFFF_FFFF) m_req++;
                if (q[24] && m_wr != 32'hFFFF_FFFF) m_wr++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
        m_req = '0;
        m_wr  = '0;
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_query  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_req     = '0;
        m_wr      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all("reset_state");

        // Single write query and its decoded fields.
        cycle("t1", 1'b1, 25'h1_ABCDEF, 1'b0, 1'b0);
        check("t1.tag_const", 64'(out_tag), 64'h2AF37);
        check("t1.set_const", 64'(out_set), 64'd5);
        check("t1.offset_const", 64'(out_offset), 64'd7);
        cycle("t1_drain", 1'b0, '0, 1'b1, 1'b0);

        // Fill to full with reads, overflow attempt, then one pop.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle("t2_fill", 1'b1, {1'b0, 24'($urandom)}, 1'b0, 1'b0);
        end
        check("t2.count_full", 64'(count), 64'd8);
        check("t2.in_ready_full", 64'(in_ready), 64'd0);
        check("t2.req_total", 64'(req_total), 64'd8);
        cycle("t2_full_pushpop", 1'b1, 25'h0_123456, 1'b1, 1'b0);
        check("t2.count_after_pop", 64'(count), 64'd7);
        check("t2.in_ready_after_pop", 64'(in_ready), 64'd1);

        // Flush with count 5 while a push is offered.
        cycle("t4_pop", 1'b0, '0, 1'b1, 1'b0);
        cycle("t4_pop", 1'b0, '0, 1'b1, 1'b0);
        check("t4.count_before", 64'(count), 64'd5);
        cycle("t4_flush", 1'b1, 25'h1_000042, 1'b1, 1'b1);
        check("t4.count_flushed", 64'(count), 64'd0);
        check("t4.req_total_kept", 64'(req_total), 64'd8);
        cycle("t4_after", 1'b1, 25'h1_000055, 1'b0, 1'b0);

        // Steady push+pop through two pointer wraps.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle("t3_fill", 1'b1, 25'(100 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle("t3_stream", 1'b1, 25'(i), 1'b1, 1'b0);
        end
        check("t3.count", 64'(count), 64'd3);
        check("t3.req_total", 64'(req_total), 64'd23);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle("rand", 1'($urandom_range(0, 99) < 60), 25'($urandom),
                  1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 4));
        end

        // Asynchronous reset between edges.
        for (int i = 0; i < 4; i++) begin
            cycle("t5_fill", 1'b1, 25'($urandom), 1'b0, 1'b0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5.out_valid", 64'(out_valid), 64'd0);
        check("t5.in_ready", 64'(in_ready), 64'd1);
        check("t5.count", 64'(count), 64'd0);
        check("t5.req_total", 64'(req_total), 64'd0);
        check("t5.write_total", 64'(write_total), 64'd0);
        mq.delete();
        m_req = '0;
        m_wr  = '0;
        @(negedge clk);
        rst = 1'b0;
        check_all("t5_release");
        cycle("t5_push", 1'b1, 25'h0_00ABCD, 1'b0, 1'b0);

        // Saturation of both statistics counters.
        force dut.req_total_q = 32'hFFFF_FFFF;
        force dut.write_total_q = 32'hFFFF_FFFF;
        #1;
        release dut.req_total_q;
        release dut.write_total_q;
        m_req = 32'hFFFF_FFFF;
        m_wr  = 32'hFFFF_FFFF;
        cycle("t6_push", 1'b1, 25'h1_FFFFFF, 1'b0, 1'b0);
        check("t6.req_sat", 64'(req_total), 64'hFFFF_FFFF);
        check("t6.wr_sat", 64'(write_total), 64'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
